// File: rtl/ber_checker_pkg.sv
// Shared definitions for the loopback BER checker: FSM encoding, symbol
// timing constants and the S(NBT,NBF) sample format also used by the
// polyphase transmit filter output.
package ber_checker_pkg;

    // Sample format S(8,7): 8 bits total, 7 fractional, two's complement.
    localparam int SMP_NBT = 8;
    localparam int SMP_NBF = 7;

    // Samples per symbol at the filter output.
    localparam int BER_OS = 4;

    // Reference PRBS period; also the delay search range and window length.
    localparam int BER_PRBS_LEN = 511;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } ber_state_e;

endpackage

// File: rtl/ber_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module ber_checker_sat_counter #(
    parameter int NB_CNT = 64
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [NB_CNT-1:0] o_count
);

    logic [NB_CNT-1:0] count_q;
    logic [NB_CNT-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_inc && !(&count_q)) begin
            count_d = count_q + NB_CNT'(1);
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/ber_checker.sv
// Receive-side BER checker: decimates the oversampled filter output at a
// selectable phase, slices each symbol on its sign, searches for the delay
// that aligns it with the reference PRBS, then counts bits and errors.
//
// Stream interface: there is no ready/backpressure. While i_enable=1 one
// sample of i_os_data is consumed every clock; i_ref_bit is consumed only
// on the symbol strobe. o_state exposes the FSM state for debug.
module ber_checker
    import ber_checker_pkg::*;
#(
    parameter int NBT_IN   = SMP_NBT,
    parameter int NBF_IN   = SMP_NBF,
    parameter int OS       = BER_OS,
    parameter int PRBS_LEN = BER_PRBS_LEN,
    parameter int NB_DLY   = $clog2(PRBS_LEN),
    parameter int NB_CNT   = 64
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic [NBT_IN-1:0]     i_os_data,
    input  logic [$clog2(OS)-1:0] i_phase_sel,
    input  logic                  i_ref_bit,
    input  logic                  i_enable,
    input  logic                  i_clear,
    output logic                  o_slice_bit,
    output logic                  o_locked,
    output logic [NB_DLY-1:0]     o_delay,
    output logic [NB_CNT-1:0]     o_bit_cnt,
    output logic [NB_CNT-1:0]     o_err_cnt,
    output logic [1:0]            o_state
);

    localparam int NB_PH = $clog2(OS);

    // The fractional width only documents the format; the slicer needs the sign.
    if (NBF_IN >= NBT_IN) begin : g_fmt_check
        $error("ber_checker: NBF_IN must be smaller than NBT_IN");
    end

    ber_state_e            state_q, state_d;
    logic [NB_PH-1:0]      phase_q, phase_d;
    logic [PRBS_LEN-2:0]   ref_sr_q, ref_sr_d;
    logic [NB_DLY-1:0]     dly_q, dly_d;
    logic [NB_DLY-1:0]     win_q, win_d;
    logic                  serr_q, serr_d;
    logic                  locked_q, locked_d;
    logic [NB_DLY-1:0]     delay_q, delay_d;
    logic                  slice_q, slice_d;

    logic                  strobe;
    logic                  slice_bit;
    logic [PRBS_LEN-1:0]   cand_vec;
    logic                  cand_bit;
    logic                  mismatch;
    logic                  cnt_clr;
    logic                  bit_inc;
    logic                  err_inc;
    logic                  unused_data;

    // Bit 1 leaves the transmit filter as a negative sample, so the MSB is the bit.
    assign slice_bit   = i_os_data[NBT_IN-1];
    assign unused_data = ^i_os_data[NBT_IN-2:0];

    assign strobe   = i_enable && (phase_q == i_phase_sel);
    // Index 0 is the current reference bit, index d is the bit d strobes ago.
    assign cand_vec = {ref_sr_q, i_ref_bit};
    assign cand_bit = cand_vec[dly_q];
    assign mismatch = slice_bit ^ cand_bit;

    // Datapath next state: phase counter, reference history and slicer.
    always_comb begin
        phase_d  = phase_q;
        ref_sr_d = ref_sr_q;
        slice_d  = slice_q;
        if (i_enable) begin
            phase_d = (phase_q == NB_PH'(OS - 1)) ? '0 : phase_q + NB_PH'(1);
        end
        if (strobe) begin
            ref_sr_d = {ref_sr_q[PRBS_LEN-3:0], i_ref_bit};
            slice_d  = slice_bit;
        end
    end

    // FSM next state: search window, delay stepping, lock and counter control.
    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        win_d    = win_q;
        serr_d   = serr_q;
        locked_d = locked_q;
        delay_d  = delay_q;
        cnt_clr  = 1'b0;
        bit_inc  = 1'b0;
        err_inc  = 1'b0;
        if (!i_enable) begin
            state_d = ST_IDLE;
        end else if ((state_q == ST_IDLE) || i_clear) begin
            // Fresh search; a strobe in this cycle is not evaluated.
            state_d  = ST_SEARCH;
            dly_d    = '0;
            win_d    = '0;
            serr_d   = 1'b0;
            locked_d = 1'b0;
            delay_d  = '0;
            cnt_clr  = 1'b1;
        end else if (strobe) begin
            case (state_q)
                ST_SEARCH: begin
                    if (win_q == NB_DLY'(PRBS_LEN - 1)) begin
                        if (!(serr_q || mismatch)) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            delay_d  = dly_q;
                        end else begin
                            dly_d  = (dly_q == NB_DLY'(PRBS_LEN - 1)) ? '0 : dly_q + NB_DLY'(1);
                            win_d  = '0;
                            serr_d = 1'b0;
                        end
                    end else begin
                        win_d  = win_q + NB_DLY'(1);
                        serr_d = serr_q || mismatch;
                    end
                end
                ST_LOCKED: begin
                    bit_inc = 1'b1;
                    err_inc = mismatch;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            ref_sr_q <= '0;
            dly_q    <= '0;
            win_q    <= '0;
            serr_q   <= 1'b0;
            locked_q <= 1'b0;
            delay_q  <= '0;
            slice_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ref_sr_q <= ref_sr_d;
            dly_q    <= dly_d;
            win_q    <= win_d;
            serr_q   <= serr_d;
            locked_q <= locked_d;
            delay_q  <= delay_d;
            slice_q  <= slice_d;
        end
    end

    ber_checker_sat_counter #(.NB_CNT(NB_CNT)) u_bit_cnt (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clear (cnt_clr),
        .i_inc   (bit_inc),
        .o_count (o_bit_cnt)
    );

    ber_checker_sat_counter #(.NB_CNT(NB_CNT)) u_err_cnt (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clear (cnt_clr),
        .i_inc   (err_inc),
        .o_count (o_err_cnt)
    );

    assign o_slice_bit = slice_q;
    assign o_locked    = locked_q;
    assign o_delay     = delay_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker: PRBS9 loopback with a known channel
// delay, error injection, phase selection, counter saturation (4-bit copy)
// and asynchronous reset / clear behaviour.
module tb_ber_checker;
    import ber_checker_pkg::*;

    localparam int NBT  = SMP_NBT;
    localparam int OSF  = BER_OS;
    localparam int PLEN = BER_PRBS_LEN;
    localparam int NBD  = $clog2(PLEN);
    localparam int NBP  = $clog2(OSF);

    // ---------------- clock / reset ----------------
    logic           clk         = 1'b0;
    logic           i_reset     = 1'b0;
    logic [NBT-1:0] i_os_data   = '0;
    logic [NBP-1:0] i_phase_sel = '0;
    logic           i_ref_bit   = 1'b0;
    logic           i_enable    = 1'b0;
    logic           i_clear     = 1'b0;

    always #5 clk = ~clk;

    logic           o_slice_bit, o_locked;
    logic [NBD-1:0] o_delay;
    logic [63:0]    o_bit_cnt, o_err_cnt;
    logic [1:0]     o_state;
    logic           s_slice_bit, s_locked;
    logic [NBD-1:0] s_delay;
    logic [3:0]     s_bit_cnt, s_err_cnt;
    logic [1:0]     s_state;

    ber_checker dut (
        .clk(clk), .i_reset(i_reset), .i_os_data(i_os_data), .i_phase_sel(i_phase_sel),
        .i_ref_bit(i_ref_bit), .i_enable(i_enable), .i_clear(i_clear),
        .o_slice_bit(o_slice_bit), .o_locked(o_locked), .o_delay(o_delay),
        .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt), .o_state(o_state)
    );

    ber_checker #(.NB_CNT(4)) dut_sat (
        .clk(clk), .i_reset(i_reset), .i_os_data(i_os_data), .i_phase_sel(i_phase_sel),
        .i_ref_bit(i_ref_bit), .i_enable(i_enable), .i_clear(i_clear),
        .o_slice_bit(s_slice_bit), .o_locked(s_locked), .o_delay(s_delay),
        .o_bit_cnt(s_bit_cnt), .o_err_cnt(s_err_cnt), .o_state(s_state)
    );

    // ---------------- stimulus + reference model state ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] lfsr = 9'h1FF;       // PRBS9, x^9 + x^5 + 1
    logic [0:0] exp_q[$];            // reference bits, newest at the back
    bit  en = 1'b0, clr = 1'b0;
    int  sel = 0;
    int  good_ph = 0;                // phase carrying the channel signal
    int  dly_t = 3;                  // channel delay in symbols
    int  lock_at_m = 4 * PLEN;       // strobes from search start to lock, 0 = never
    int  n_strobe = 0;

    int  ph_m = 0;
    bit  run_m = 1'b0;
    int  scnt_m = 0;
    bit  locked_m = 1'b0;
    longint unsigned bits_m = 0, errs_m = 0;
    bit  slice_m = 1'b0;

    function automatic logic [3:0] sat4(input longint unsigned v);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    task automatic model_reset();
        ph_m = 0; run_m = 1'b0; scnt_m = 0; locked_m = 1'b0;
        bits_m = 0; errs_m = 0; slice_m = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // One clock: drive inputs at the falling edge, advance the model, return
    // at the next falling edge with DUT outputs settled.
    task automatic tick(input bit inj_err, input bit force_neg);
        bit strobe, rb, sb;
        logic [NBT-1:0] smp;
        int nq;
        strobe = en && (ph_m == sel);
        rb = 1'($urandom_range(0, 1));
        if (strobe) begin
            rb = lfsr[8] ^ lfsr[4];
            lfsr = {lfsr[7:0], rb};
            exp_q.push_back(rb);
            if (exp_q.size() > 2 * PLEN) void'(exp_q.pop_front());
            n_strobe++;
        end
        nq = exp_q.size();
        smp = NBT'($urandom);
        if (en && (ph_m == good_ph) && (nq > dly_t)) begin
            sb = exp_q[nq-1-dly_t][0] ^ inj_err;
            smp = sb ? NBT'(32'd0 - $urandom_range(1, 128)) : NBT'($urandom_range(0, 127));
        end
        if (force_neg) smp[NBT-1] = 1'b1;
        i_os_data = smp; i_ref_bit = rb; i_enable = en; i_clear = clr;
        i_phase_sel = NBP'(sel);
        if (strobe) slice_m = smp[NBT-1];
        if (!en) begin
            run_m = 1'b0;
        end else if (!run_m || clr) begin
            run_m = 1'b1; scnt_m = 0; locked_m = 1'b0; bits_m = 0; errs_m = 0;
        end else if (strobe) begin
            scnt_m++;
            if (locked_m) begin
                bits_m++;
                if (smp[NBT-1] != exp_q[nq-1-dly_t][0]) errs_m++;
            end else if ((lock_at_m != 0) && (scnt_m == lock_at_m)) begin
                locked_m = 1'b1;
            end
        end
        if (en) ph_m = (ph_m + 1) % OSF;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_strobe(input bit inj);
        int start;
        start = n_strobe;
        for (int k = 0; (k < 2 * OSF) && (n_strobe == start); k++) tick(inj, 1'b0);
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
    endtask

    task automatic wait_lock(input int max_ticks, output bit got, output int at_strobe);
        got = 1'b0;
        at_strobe = -1;
        for (int k = 0; (k < max_ticks) && !got; k++) begin
            tick(1'b0, 1'b0);
            if (o_locked === 1'b1) begin
                got = 1'b1;
                at_strobe = scnt_m;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_reset = 1'b0; en = 1'b0;
        repeat (4) begin
            i_os_data = NBT'($urandom); i_ref_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        tests_run++; if (o_locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %0d want 0", o_locked); end
        tests_run++; if (o_delay !== '0) begin tests_failed++; $display("FAIL reset_delay: got %0d want 0", o_delay); end
        tests_run++; if (o_bit_cnt !== 64'd0) begin tests_failed++; $display("FAIL reset_bit_cnt: got %0d want 0", o_bit_cnt); end
        tests_run++; if (o_err_cnt !== 64'd0) begin tests_failed++; $display("FAIL reset_err_cnt: got %0d want 0", o_err_cnt); end
        tests_run++; if (o_slice_bit !== 1'b0) begin tests_failed++; $display("FAIL reset_slice: got %0d want 0", o_slice_bit); end
        tests_run++; if (o_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", o_state); end
        tests_run++; if ({s_locked, s_bit_cnt, s_err_cnt} !== 9'd0) begin tests_failed++; $display("FAIL reset_sat_outputs: got %0h want 0", {s_locked, s_bit_cnt, s_err_cnt}); end
        i_reset = 1'b1;
        model_reset();
        repeat (12) tick(1'b0, 1'b0);
        tests_run++; if ({o_locked, o_slice_bit, o_state} !== 4'd0 || o_bit_cnt !== 64'd0) begin tests_failed++; $display("FAIL idle_outputs: got locked=%0d slice=%0d state=%0d bits=%0d want 0", o_locked, o_slice_bit, o_state, o_bit_cnt); end
        // Phase counter must still be 0: the first enabled cycle is a phase-0 strobe.
        sel = 0; en = 1'b1;
        tick(1'b0, 1'b1);
        tests_run++; if (o_slice_bit !== slice_m) begin tests_failed++; $display("FAIL idle_phase_hold: slice got %0d want %0d", o_slice_bit, slice_m); end
    endtask

    task automatic test_loopback();
        bit got; int at;
        wait_lock(4 * PLEN * OSF + 64, got, at);
        tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL loop_lock: locked got 0 want 1"); end
        tests_run++; if (at !== 4 * PLEN) begin tests_failed++; $display("FAIL loop_lock_time: strobes got %0d want %0d", at, 4 * PLEN); end
        tests_run++; if (o_delay !== NBD'(3)) begin tests_failed++; $display("FAIL loop_delay: got %0d want 3", o_delay); end
        repeat (1000) run_strobe(1'b0);
        tests_run++; if (o_bit_cnt !== 64'd1000 || o_bit_cnt !== 64'(bits_m)) begin tests_failed++; $display("FAIL loop_bit_cnt: got %0d want 1000 (model %0d)", o_bit_cnt, bits_m); end
        tests_run++; if (o_err_cnt !== 64'd0) begin tests_failed++; $display("FAIL loop_err_cnt: got %0d want 0", o_err_cnt); end
        tests_run++; if (o_slice_bit !== slice_m) begin tests_failed++; $display("FAIL loop_slice: got %0d want %0d", o_slice_bit, slice_m); end
        tests_run++; if (s_bit_cnt !== sat4(bits_m)) begin tests_failed++; $display("FAIL loop_sat_bit_cnt: got %0d want %0d", s_bit_cnt, sat4(bits_m)); end
    endtask

    task automatic test_error_inject();
        for (int k = 0; k < 40; k++) run_strobe((k == 2) || (k == 9) || (k == 10) || (k == 23) || (k == 37));
        tests_run++; if (o_err_cnt !== 64'd5 || o_err_cnt !== 64'(errs_m)) begin tests_failed++; $display("FAIL inj_err_cnt: got %0d want 5 (model %0d)", o_err_cnt, errs_m); end
        tests_run++; if (o_bit_cnt !== 64'd1040) begin tests_failed++; $display("FAIL inj_bit_cnt: got %0d want 1040", o_bit_cnt); end
        tests_run++; if (o_locked !== 1'b1) begin tests_failed++; $display("FAIL inj_still_locked: got %0d want 1", o_locked); end
    endtask

    task automatic test_phase_select();
        bit got, seen; int at;
        sel = 2; good_ph = 2; dly_t = 0; lock_at_m = PLEN;
        pulse_clear();
        tests_run++; if (o_locked !== 1'b0 || o_bit_cnt !== 64'd0) begin tests_failed++; $display("FAIL ph_clear: locked=%0d bits=%0d want 0 0", o_locked, o_bit_cnt); end
        wait_lock(PLEN * OSF + 64, got, at);
        tests_run++; if (got !== 1'b1 || at !== PLEN) begin tests_failed++; $display("FAIL ph2_lock: got=%0d strobes=%0d want 1 %0d", got, at, PLEN); end
        tests_run++; if (o_delay !== NBD'(0)) begin tests_failed++; $display("FAIL ph2_delay: got %0d want 0", o_delay); end
        sel = 0; lock_at_m = 0;
        pulse_clear();
        seen = 1'b0;
        repeat (2000) begin
            run_strobe(1'b0);
            if (o_locked !== 1'b0) seen = 1'b1;
        end
        tests_run++; if (seen !== locked_m) begin tests_failed++; $display("FAIL ph0_no_lock: locked seen %0d want %0d", seen, locked_m); end
    endtask

    task automatic test_saturation();
        bit got; int at;
        sel = 0; good_ph = 0; dly_t = 3; lock_at_m = 4 * PLEN;
        pulse_clear();
        wait_lock(4 * PLEN * OSF + 64, got, at);
        tests_run++; if (got !== 1'b1 || s_locked !== 1'b1) begin tests_failed++; $display("FAIL sat_lock: got %0d/%0d want 1/1", got, s_locked); end
        for (int k = 0; k < 25; k++) run_strobe(k < 20);
        tests_run++; if (s_err_cnt !== 4'd15 || s_err_cnt !== sat4(errs_m)) begin tests_failed++; $display("FAIL sat_err_cnt: got %0d want 15", s_err_cnt); end
        tests_run++; if (s_bit_cnt !== 4'd15) begin tests_failed++; $display("FAIL sat_bit_cnt: got %0d want 15", s_bit_cnt); end
        tests_run++; if (o_err_cnt !== 64'd20 || o_bit_cnt !== 64'd25) begin tests_failed++; $display("FAIL wide_cnt: err=%0d bits=%0d want 20 25", o_err_cnt, o_bit_cnt); end
        repeat (5) run_strobe(1'b1);
        tests_run++; if (s_err_cnt !== 4'd15 || o_err_cnt !== 64'(errs_m)) begin tests_failed++; $display("FAIL sat_hold: sat=%0d wide=%0d want 15 %0d", s_err_cnt, o_err_cnt, errs_m); end
    endtask

    task automatic test_async_reset();
        bit got; int at;
        #2 i_reset = 1'b0;
        #1;
        tests_run++; if (o_locked !== 1'b0 || o_delay !== '0) begin tests_failed++; $display("FAIL async_lock_delay: locked=%0d delay=%0d want 0 0", o_locked, o_delay); end
        tests_run++; if (o_bit_cnt !== 64'd0 || o_err_cnt !== 64'd0 || s_err_cnt !== 4'd0) begin tests_failed++; $display("FAIL async_counters: bits=%0d errs=%0d sat_errs=%0d want 0", o_bit_cnt, o_err_cnt, s_err_cnt); end
        @(negedge clk);
        i_reset = 1'b1;
        model_reset();
        wait_lock(4 * PLEN * OSF + 64, got, at);
        tests_run++; if (got !== 1'b1 || at !== 4 * PLEN || o_delay !== NBD'(3)) begin tests_failed++; $display("FAIL relock: got=%0d strobes=%0d delay=%0d want 1 %0d 3", got, at, o_delay, 4 * PLEN); end
        repeat (10) run_strobe(1'b0);
        pulse_clear();
        tests_run++; if (o_locked !== 1'b0 || o_bit_cnt !== 64'd0) begin tests_failed++; $display("FAIL clear_locked: locked=%0d bits=%0d want 0 0", o_locked, o_bit_cnt); end
        wait_lock(4 * PLEN * OSF + 64, got, at);
        tests_run++; if (got !== 1'b1 || at !== 4 * PLEN || o_delay !== NBD'(3)) begin tests_failed++; $display("FAIL clear_research: got=%0d strobes=%0d delay=%0d want 1 %0d 3", got, at, o_delay, 4 * PLEN); end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_loopback();
        test_error_inject();
        test_phase_select();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ber_checker.md
Name: ber_checker

Overview:
- Receive-side checker that consumes the S(8,7) oversampled output of the polyphase transmit filter, one sample per clock.
- Decimates by OS at a selectable phase and slices each symbol to one bit.
- Aligns the sliced stream to the reference PRBS bit stream through a delay search, then counts bit errors.
- Sits directly downstream of the filter in the loopback test path; the reference bits come from the same PRBS that feeds the filter.

Parameters:
- NBT_IN, 8, total bits of the input sample (signed).
- NBF_IN, 7, fractional bits of the input sample (informational only; the slicer uses the sign).
- OS, 4, oversampling factor (samples per symbol).
- PRBS_LEN, 511, reference sequence period. Also the maximum delay searched and the search window length, in symbols.
- NB_DLY, 9, width of the delay index; NB_DLY = $clog2(PRBS_LEN).
- NB_CNT, 64, width of the bit and error counters.

Ports:
- clk, in, 1, system clock.
- i_reset, in, 1, asynchronous, active-low reset.
- i_os_data, in, NBT_IN, signed filter output sample, valid every clock while i_enable=1.
- i_phase_sel, in, $clog2(OS), decimation phase to sample.
- i_ref_bit, in, 1, reference transmitted bit; sampled only on the symbol strobe.
- i_enable, in, 1, run enable.
- i_clear, in, 1, synchronous restart of the search (single-cycle pulse).
- o_slice_bit, out, 1, last sliced bit.
- o_locked, out, 1, alignment found.
- o_delay, out, NB_DLY, delay at which lock was found.
- o_bit_cnt, out, NB_CNT, symbols compared while locked.
- o_err_cnt, out, NB_CNT, mismatches while locked.

Behaviour:
- Reset (asynchronous, i_reset=0):
  - All outputs are 0, state = IDLE, phase counter = 0.
  - The reference shift register, window counter and search error count are cleared.
  - Reset takes effect immediately, including mid-SEARCH and mid-LOCKED.
- Phase counter:
  - Increments modulo OS every clock while i_enable=1; holds while i_enable=0.
  - Symbol strobe = i_enable & (phase counter == i_phase_sel).
  - i_phase_sel may change at any time; it takes effect on the next compare.
- Slicer:
  - Sliced bit = i_os_data[NBT_IN-1] (MSB), because the transmit filter maps bit 1 to a negative sample. A value of 0 slices to 0.
  - o_slice_bit is registered one clock after the strobe.
- Reference buffer:
  - PRBS_LEN-1 bit shift register, shifting i_ref_bit in on every strobe.
  - Candidate reference for delay d = {ref_sr, i_ref_bit}[d]; d=0 is the current i_ref_bit.
- Mismatch: mismatch = sliced bit XOR candidate reference, evaluated on the strobe.
- FSM states: IDLE, SEARCH, LOCKED.
- IDLE:
  - Counters hold their values.
  - i_enable=1 → SEARCH, with d=0, window=0, search_err=0, o_bit_cnt=0, o_err_cnt=0, o_locked=0.
- SEARCH, on each strobe:
  - window += 1 and search_err |= mismatch.
  - When window reaches PRBS_LEN with search_err=0: → LOCKED, o_locked=1 and o_delay=d, in the same cycle the transition registers.
  - When window reaches PRBS_LEN with search_err=1: d = (d==PRBS_LEN-1) ? 0 : d+1, window=0, search_err=0. The search wraps indefinitely.
- LOCKED, on each strobe:
  - o_bit_cnt += 1 and o_err_cnt += mismatch, both registered one clock after the strobe.
  - Each counter saturates at all-ones and never wraps.
  - There is no automatic loss of lock.
- Leaving a state:
  - i_enable=0 in any state → IDLE next clock. o_locked and the counters hold.
  - i_clear=1 (takes priority over a strobe in the same cycle) → re-enter SEARCH as from IDLE, provided i_enable=1; with i_enable=0 the block goes to IDLE.
- Boundary conditions:
  - A strobe in the cycle of the window-end transition is counted by the old state only.
  - The first strobe in LOCKED is the one after the transition.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, SEARCH=2'd1, LOCKED=2'd2).
  - PRBS_LEN.
  - OS.
  - The S(NBT,NBF) sample format constants, which the polyph_filter output also uses.
- One sub-module: sat_counter (NB_CNT-wide, increment enable, synchronous clear, saturating), instantiated twice for o_bit_cnt and o_err_cnt.

Test Plan:
- Reset: drive random i_os_data with i_reset=0 → all outputs 0; release and hold i_enable=0 → outputs stay 0, and the phase counter stays 0.
- Loopback with a 3-symbol delay: PRBS9 drives i_ref_bit, the slicer input is the sign of the reference delayed 3 strobes, i_phase_sel=0 → o_locked rises after 4·511=2044 strobes (8176 clocks), o_delay=3, o_err_cnt stays 0, and o_bit_cnt=1000 after 1000 further strobes.
- Error injection: once locked, invert the sample sign on 5 chosen strobes → o_err_cnt=5; o_bit_cnt increments every strobe.
- Phase select: only phase 2 carries the correct sign and the other phases carry random data → i_phase_sel=2 locks at d=0 after 511 strobes; i_phase_sel=0 never locks within 511·511 strobes.
- Saturation with NB_CNT=4: lock, then force 20 errors → o_err_cnt=15 and holds; o_bit_cnt=15.
- Asynchronous reset mid-LOCKED: assert i_reset=0 between clock edges → o_locked, o_delay and the counters drop to 0 without a clock edge. After release with i_enable=1, the block re-locks at the same delay; also pulse i_clear while locked → re-search from d=0.
